seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexing scan controller that shares one binary-to-7-segment decoder across a 4-digit common display. It holds a double-buffered 4-digit value and steps through the digits at a programmable slot rate, presenting one 4-bit code at a time to the decoder. It drives the decoder enable and the one-hot digit select, inserts anti-ghosting blank time, and optionally suppresses leading zeros. It sits between the register/bus logic that produces the value and the shared decoder plus digit drivers.

## Interface
- PRESCALE, 1000: clock cycles per digit slot; legal range 4 to 65535.
- BLANK, 50: cycles at the start of each slot with all digits off; legal range 0 to PRESCALE-2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  scan enable; 0 forces the display dark.
- load  in  1  one-cycle request to capture value and lz into the shadow buffer.
- value  in  16  four 4-bit codes; digit 0 (least significant, rightmost) is [3:0], digit 3 is [15:12].
- lz  in  1  leading-zero suppress, captured together with value.
- load_ack  out  1  one-cycle pulse the cycle after load is sampled.
- pending  out  1  shadow holds a value not yet transferred to the active buffer.
- bin  out  4  code to the shared decoder input.
- dec_en  out  1  decoder enable; 0 makes the decoder output all zeros.
- dig_sel  out  4  one-hot digit select, active-high; bit k selects digit k.
- frame  out  1  one-cycle pulse in the first cycle of each new frame.

## Operation
- Reset: state is IDLE. slot_cnt=0, digit=0, shadow=0, active=0, lz regs=0, pending=0. All outputs are 0.
- All outputs are decoded from registers only. There is no combinational path from any input to any output.
- Shadow buffer, when load=1 at an edge:
  - shadow<=value and shadow_lz<=lz; pending<=1; load_ack=1 for the next cycle.
  - A load while pending=1 overwrites the shadow (last write wins) and still acks.
- Transfer (active<=shadow, pending<=0) happens only at a frame boundary (the edge ending digit 3's slot) or on any edge while in IDLE with pending=1.
- Load and transfer on the same edge:
  - The old shadow goes to active.
  - The new value goes to shadow.
  - pending stays 1.
- FSM states are IDLE, BLANK and SHOW.
- IDLE:
  - dig_sel=0, dec_en=0, bin=0; counters are held at 0.
  - en=1 moves to BLANK, or to SHOW if BLANK=0, with digit=0 and slot_cnt=0.
- BLANK:
  - dig_sel=0, dec_en=0; bin = active nibble of the current digit (setup time for the decoder).
  - At slot_cnt==BLANK-1, moves to SHOW.
- SHOW:
  - dig_sel = one-hot(digit); bin = active nibble.
  - dec_en=1 unless the digit is suppressed.
- Slot end (slot_cnt==PRESCALE-1, in any scanning state):
  - slot_cnt<=0; digit<=digit+1, wrapping 3 to 0.
  - Next state is BLANK, or SHOW if BLANK=0.
  - If digit was 3, this edge is a frame boundary and frame pulses next cycle.
- en=0 in any state moves to IDLE at the next edge; counters are cleared. Re-enable always restarts at digit 0.
- Suppression: digit k (k=1..3) is suppressed when active_lz=1 and active nibbles k..3 are all zero. Digit 0 is never suppressed. A suppressed digit keeps dig_sel asserted but has dec_en=0.
- Codes 10 to 15 are passed through unchanged; the decoder blanks them.

## Timing
- en sampled 1 at edge t: BLANK outputs from t+1; first SHOW cycle at t+1+BLANK.
- Slot = exactly PRESCALE cycles; frame = 4*PRESCALE cycles; frame pulses are exactly 4*PRESCALE apart while en=1.
- Display time per digit = PRESCALE-BLANK cycles.
- load at edge t: load_ack high in cycle t+1, pending=1 from t+1.
  - While scanning, the new value is first visible at digit 0 of the frame after the next boundary.
  - In IDLE, the transfer happens at edge t+1.
- en=0 at edge t: dig_sel=0 and dec_en=0 from t+1.
- rst_n low: all outputs go to 0 immediately, with no clock edge needed; operation resumes at the first edge after release.

## Test plan
- Reset: assert rst_n=0 mid-SHOW without a clock edge -> all outputs 0 immediately; after release, state is IDLE and pending=0.
- Basic scan, PRESCALE=8, BLANK=2, load 16'h1234, en=1:
  - Each slot gives 2 cycles with dig_sel=0, then 6 cycles showing the digit: dig_sel=0001/bin=4, 0010/3, 0100/2, 1000/1.
  - frame pulses every 32 cycles.
- Leading zeros, lz=1:
  - value 16'h0050 -> digits 3 and 2 have dec_en=0; digit 1 shows bin=5 with dec_en=1; digit 0 shows bin=0 with dec_en=1.
  - value 16'h0000 -> only digit 0 has dec_en=1.
- Double buffer:
  - Load 16'hAAAA mid-frame, then 16'h5555 two cycles later -> load_ack pulses twice; bin keeps the old value until the boundary; pending=1 until the boundary; the next frame shows 5.
- Boundary collision: with pending=1, load 16'h9999 on the boundary edge -> the old shadow is displayed and pending stays 1; 9999 appears one frame later.
- Enable drop: en=0 during SHOW of digit 2 -> dig_sel=0 next cycle; en=1 again -> restarts with a BLANK slot for digit 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: bundle between the value-producing bus logic and the scan
// controller, plus the decoder/digit-driver side outputs.
//   en, load, value[15:0], lz   : written by the bus side (master)
//   load_ack, pending           : shadow-buffer status back to the bus side
//   bin[3:0], dec_en, dig_sel[3:0], frame : scan outputs to decoder/drivers
interface seg7_scan_if;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic        lz;
    logic        load_ack;
    logic        pending;
    logic [3:0]  bin;
    logic        dec_en;
    logic [3:0]  dig_sel;
    logic        frame;

    modport master (
        output en, load, value, lz,
        input  load_ack, pending, bin, dec_en, dig_sel, frame
    );

    modport slave (
        input  en, load, value, lz,
        output load_ack, pending, bin, dec_en, dig_sel, frame
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for a 4-digit display that
// shares one binary-to-7-segment decoder. Double-buffers the displayed value
// (shadow -> active at frame boundaries), blanks the start of every digit slot
// against ghosting, and optionally suppresses leading zeros.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : seg7_scan_if.slave (en/load/value/lz in; load_ack/pending/bin/
//            dec_en/dig_sel/frame out)
// Parameters:
//   PRESCALE : cycles per digit slot (4..65535)
//   BLANK    : dark cycles at the start of each slot (0..PRESCALE-2)
module seg7_scan_ctrl #(
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_SHOW} state_t;

    localparam logic [15:0] SLOT_LAST  = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    // With no blank time a slot opens directly in SHOW.
    localparam state_t      SLOT_START = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    state_t      state;
    logic [15:0] slot_cnt;
    logic [1:0]  digit;
    logic [15:0] shadow;
    logic [15:0] active;
    logic        shadow_lz;
    logic        active_lz;
    logic        pending;
    logic        load_ack;
    logic        frame;

    logic        scanning;
    logic        slot_end;
    logic        boundary;
    logic        xfer;
    logic [3:0]  cur_nib;
    logic        supp;

    assign scanning = (state != ST_IDLE);
    assign slot_end = scanning && (slot_cnt == SLOT_LAST);
    // Only a slot end that actually continues scanning counts as a boundary;
    // a simultaneous en=0 drops to IDLE, where any pending value moves anyway.
    assign boundary = slot_end && bus.en && (digit == 2'd3);
    assign xfer     = pending && (boundary || (state == ST_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            slot_cnt  <= '0;
            digit     <= '0;
            shadow    <= '0;
            active    <= '0;
            shadow_lz <= 1'b0;
            active_lz <= 1'b0;
            pending   <= 1'b0;
            load_ack  <= 1'b0;
            frame     <= 1'b0;
        end else begin
            load_ack <= bus.load;
            frame    <= 1'b0;

            // The transfer reads the old shadow, so a load on the same edge
            // lands in the shadow and leaves pending set.
            if (xfer) begin
                active    <= shadow;
                active_lz <= shadow_lz;
            end
            if (bus.load) begin
                shadow    <= bus.value;
                shadow_lz <= bus.lz;
                pending   <= 1'b1;
            end else if (xfer) begin
                pending   <= 1'b0;
            end

            if (!bus.en) begin
                state    <= ST_IDLE;
                slot_cnt <= '0;
                digit    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= SLOT_START;
                        slot_cnt <= '0;
                        digit    <= '0;
                    end
                    default: begin
                        if (slot_end) begin
                            slot_cnt <= '0;
                            digit    <= digit + 2'd1;
                            state    <= SLOT_START;
                            frame    <= (digit == 2'd3);
                        end else begin
                            slot_cnt <= slot_cnt + 16'd1;
                            if (state == ST_BLANK && slot_cnt == BLANK_LAST)
                                state <= ST_SHOW;
                        end
                    end
                endcase
            end
        end
    end

    assign cur_nib = active[{digit, 2'b00} +: 4];

    // Digit k blanks when it and every more-significant digit are zero.
    always_comb begin
        supp = 1'b0;
        case (digit)
            2'd1:    supp = (active[15:4]  == 12'd0);
            2'd2:    supp = (active[15:8]  == 8'd0);
            2'd3:    supp = (active[15:12] == 4'd0);
            default: supp = 1'b0;
        endcase
        supp = supp && active_lz;
    end

    assign bus.bin      = scanning ? cur_nib : 4'd0;
    assign bus.dig_sel  = (state == ST_SHOW) ? (4'b0001 << digit) : 4'b0000;
    assign bus.dec_en   = (state == ST_SHOW) && !supp;
    assign bus.pending  = pending;
    assign bus.load_ack = load_ack;
    assign bus.frame    = frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with PRESCALE=8, BLANK=2. Expected per-cycle
// outputs are pushed to a queue as stimulus is planned and popped one per
// cycle when the DUT output is sampled on the falling edge.
module tb_seg7_scan_ctrl;

    localparam int P = 8;
    localparam int B = 2;
    localparam int FRAME = 4 * P;

    typedef struct packed {
        logic [3:0] dig_sel;
        logic [3:0] bin;
        logic       dec_en;
        logic       frame;
        logic       ack;
        logic       pend;
    } exp_t;

    logic clk;
    logic rst_n;
    seg7_scan_if bus ();

    seg7_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t e;
    exp_t obs;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before timeout");
        $fatal(1);
    end

    // Expected outputs for cycle i after a scan start (cycle 0 = first BLANK cycle).
    function automatic exp_t scan_exp(int i, logic [15:0] val, logic lz,
                                      logic ack, logic pend);
        exp_t r;
        int d;
        int pos;
        d   = (i / P) % 4;
        pos = i % P;
        r.bin   = 4'((val >> (4 * d)) & 16'hF);
        r.frame = (i > 0) && (i % FRAME == 0);
        r.ack   = ack;
        r.pend  = pend;
        if (pos < B) begin
            r.dig_sel = 4'b0000;
            r.dec_en  = 1'b0;
        end else begin
            r.dig_sel = 4'(1 << d);
            r.dec_en  = !(lz && d != 0 && ((val >> (4 * d)) == 16'd0));
        end
        return r;
    endfunction

    function automatic exp_t sample();
        return {bus.dig_sel, bus.bin, bus.dec_en, bus.frame, bus.load_ack, bus.pending};
    endfunction

    // Go idle, optionally load a value (transferred while idle), then enable.
    task automatic start_scan(logic [15:0] val, logic lz, logic do_load);
        @(negedge clk);
        bus.en = 1'b0; bus.load = do_load; bus.value = val; bus.lz = lz;
        @(negedge clk);
        bus.load = 1'b0;
        @(negedge clk);
        bus.en = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.en = 1'b0; bus.load = 1'b0; bus.value = '0; bus.lz = 1'b0;
        #1;
        obs = sample();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs, 12'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got %b want %b", obs, 12'b0);
        end
    endtask

    task automatic test_basic_scan();
        start_scan(16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 2 * FRAME + 8; i++) sb.push_back(scan_exp(i, 16'h1234, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2 * FRAME + 8; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL basic_scan cyc %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    task automatic test_leading_zeros(logic [15:0] val);
        start_scan(val, 1'b1, 1'b1);
        for (int i = 0; i < FRAME; i++) sb.push_back(scan_exp(i, val, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL lz_%h cyc %0d: got %b want %b", val, i, obs, e);
            end
        end
    endtask

    task automatic test_double_buffer();
        start_scan(16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 2 * FRAME; i++)
            sb.push_back(scan_exp(i, (i < FRAME) ? 16'h1234 : 16'h5555, 1'b0,
                                  (i == 11 || i == 13), (i >= 11 && i < FRAME)));
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL double_buffer cyc %0d: got %b want %b", i, obs, e);
            end
            bus.load = (i == 10 || i == 12);
            bus.value = (i == 10) ? 16'hAAAA : 16'h5555;
        end
        bus.load = 1'b0;
    endtask

    task automatic test_boundary_collision();
        logic [15:0] v;
        start_scan(16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 3 * FRAME; i++) begin
            v = (i < FRAME) ? 16'h1234 : (i < 2 * FRAME) ? 16'hAAAA : 16'h9999;
            sb.push_back(scan_exp(i, v, 1'b0, (i == 21 || i == FRAME),
                                  (i >= 21 && i < 2 * FRAME)));
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL boundary_collision cyc %0d: got %b want %b", i, obs, e);
            end
            bus.load = (i == 20 || i == FRAME - 1);
            bus.value = (i == 20) ? 16'hAAAA : 16'h9999;
        end
        bus.load = 1'b0;
    endtask

    task automatic test_enable_drop();
        start_scan(16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 23 + 2 * P; i++) begin
            if (i <= 20)      sb.push_back(scan_exp(i, 16'h1234, 1'b0, 1'b0, 1'b0));
            else if (i < 23)  sb.push_back('0);
            else              sb.push_back(scan_exp(i - 23, 16'h1234, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 23 + 2 * P; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL enable_drop cyc %0d: got %b want %b", i, obs, e);
            end
            if (i == 20) bus.en = 1'b0;
            if (i == 22) bus.en = 1'b1;
        end
    endtask

    task automatic test_reset_mid_show();
        start_scan(16'h1234, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) sb.push_back(scan_exp(i, 16'h1234, 1'b0, (i == 4), (i >= 4)));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pre_reset cyc %0d: got %b want %b", i, obs, e);
            end
            bus.load = (i == 3);
            bus.value = 16'h5678;
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = sample(); n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want %b", obs, 12'b0);
        end
        @(negedge clk);
        bus.en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        obs = sample(); n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b want %b", obs, 12'b0);
        end
        // No load: the active buffer must have been cleared by reset.
        start_scan(16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < FRAME; i++) sb.push_back(scan_exp(i, 16'h0000, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            obs = sample(); e = sb.pop_front(); n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL post_reset_scan cyc %0d: got %b want %b", i, obs, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_leading_zeros(16'h0050);
        test_leading_zeros(16'h0000);
        test_double_buffer();
        test_boundary_collision();
        test_enable_drop();
        test_reset_mid_show();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
